pipeline_fetch_controller: RTL
==============================

// Module: pipeline_fetch_controller
// PURPOSE
// Instruction-fetch sequencer for the pipelined LEGv8 core. Owns the PC, drives the
// byte-addressed instruction memory, waits a fixed number of cycles for its
// combinational read delay, then loads the IF/ID register. Handles hazard stalls,
// branch redirect/flush and illegal fetch addresses.
// PARAMETERS
// RESET_PC     0    PC value after reset
// MEM_BYTES    128  instruction memory size in bytes; legal PC range 0..MEM_BYTES-4
// MEM_LATENCY  2    cycles imem_addr is held before imem_instr is sampled (>=1);
//                   MEM_LATENCY * clock period must exceed the memory read delay
// PORTS
// clk            in   1   rising-edge clock
// reset_n        in   1   asynchronous, active-low reset
// imem_addr      out  64  fetch address to instruction memory (= pc)
// imem_instr     in   32  instruction word from memory
// stall          in   1   hazard unit: hold IF/ID and do not accept a new word
// branch_taken   in   1   redirect request, sampled each cycle
// branch_target  in   64  redirect PC, valid with branch_taken
// if_id_pc       out  64  PC of instruction in IF/ID
// if_id_instr    out  32  instruction in IF/ID
// if_id_valid    out  1   IF/ID holds a real instruction (0 = bubble)
// fetch_fault    out  1   PC misaligned or out of range; fetch halted
// fetch_count    out  32  number of words loaded into IF/ID, wraps at 2^32
// BEHAVIOUR
// - Reset (async, reset_n=0): pc=RESET_PC, wait_cnt=0, state=FETCH; if_id_pc=0,
//   if_id_instr=0, if_id_valid=0, fetch_fault=0, fetch_count=0. Reset mid-wait drops the word.
// - imem_addr = pc combinationally in every state. legal(pc) = pc[1:0]==0 && pc<=MEM_BYTES-4.
// - States: FETCH, HOLD, FAULT. ready = (state==FETCH && wait_cnt==MEM_LATENCY-1).
// - Priority per cycle: branch_taken > fault check > ready/stall > counting.
// - branch_taken=1 (any state): pc<=branch_target, wait_cnt<=0, if_id_valid<=0 (flush,
//   even when stall=1), any word in flight/HOLD discarded; next state FETCH if
//   legal(branch_target) else FAULT.
// - FETCH, !legal(pc): -> FAULT, fetch_fault<=1, memory not sampled.
// - FETCH, !ready: wait_cnt++; if stall=0, if_id_valid<=0 (bubble); stall=1 holds IF/ID.
// - FETCH, ready, stall=0: if_id_instr<=imem_instr, if_id_pc<=pc, if_id_valid<=1,
//   fetch_count++, pc<=pc+4, wait_cnt<=0, stay FETCH.
// - FETCH, ready, stall=1: -> HOLD; pc and wait_cnt frozen, IF/ID unchanged.
// - HOLD, stall=1: no change. HOLD, stall=0: load IF/ID from imem_instr exactly as
//   ready case (address has been stable, word is valid), pc<=pc+4, -> FETCH, wait_cnt=0.
// - FAULT: fetch_fault=1, pc frozen; stall=0 writes bubble (if_id_valid<=0). Exit only
//   via reset or branch to legal target (fetch_fault<=0 same edge).
// - pc+4 beyond MEM_BYTES-4 is not wrapped; it faults on the next FETCH cycle.
// - MEM_LATENCY=1: one word per cycle with stall=0. wait_cnt width = clog2(MEM_LATENCY+1).
// - Throughput with stall=0: one valid word every MEM_LATENCY cycles, bubbles between.
// TESTING (MEM_LATENCY=2, MEM_BYTES=128, memory words at 0,16,32,48 per loaded program)
// - Reset release, stall=0 -> if_id_valid pulses every 2nd cycle; PCs 0,4,8,...;
//   word at PC 0 = 32'h8B1F03E5, at PC 16 = 32'hF84000A4.
// - stall=1 for 5 cycles while word at PC 8 ready -> IF/ID holds PC 4, pc stays 8;
//   on release PC 8 loaded next edge, fetch_count +1 exactly once.
// - branch_taken with target 32 during HOLD and stall=1 -> if_id_valid=0 next edge,
//   then PC 32 word 32'h8B040086 delivered 2 cycles later; held word never appears.
// - Sequential run to PC 124 -> PC 124 delivered, then fetch_fault=1, pc=128,
//   only bubbles; branch to 48 clears fault, delivers 32'hF80010A6.
// - branch_target=6 -> FAULT next cycle, no memory sample; reset_n low mid-wait ->
//   all outputs to reset values immediately, restart at RESET_PC.
// - ready and branch_taken same cycle -> branch wins, fetch_count unchanged.

Source files
------------

// File: rtl/pipeline_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_fetch_controller
// Description : Instruction-fetch sequencer for the pipelined LEGv8 core.
//               Owns the PC and presents it to a byte-addressed instruction
//               memory. It holds each address for MEM_LATENCY cycles to cover
//               the memory's combinational read delay, then loads the IF/ID
//               register. Handles hazard stalls, branch redirect/flush and
//               illegal fetch addresses.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i            in   1   rising-edge clock
//   reset_n_i        in   1   asynchronous active-low reset
//   imem_addr_o      out  64  fetch address (= pc)
//   imem_instr_i     in   32  instruction word from memory
//   stall_i          in   1   hold IF/ID, do not accept a new word
//   branch_taken_i   in   1   redirect request
//   branch_target_i  in   64  redirect PC
//   if_id_pc_o       out  64  PC of instruction in IF/ID
//   if_id_instr_o    out  32  instruction in IF/ID
//   if_id_valid_o    out  1   IF/ID holds a real instruction
//   fetch_fault_o    out  1   PC misaligned or out of range, fetch halted
//   fetch_count_o    out  32  words loaded into IF/ID (wraps)
// ============================================================================
module pipeline_fetch_controller #(
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int unsigned MEM_BYTES   = 128,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  output logic [63:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [63:0] branch_target_i,
  output logic [63:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o,
  output logic        fetch_fault_o,
  output logic [31:0] fetch_count_o
);

  localparam int unsigned       WAIT_W    = $clog2(MEM_LATENCY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LATENCY - 1);
  localparam logic [63:0]       PC_MAX    = 64'(MEM_BYTES) - 64'd4;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [63:0]       pc_q, pc_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [63:0]       if_pc_q, if_pc_d;
  logic [31:0]       if_instr_q, if_instr_d;
  logic              if_valid_q, if_valid_d;
  logic              fault_q, fault_d;
  logic [31:0]       count_q, count_d;
  logic              ready;

  function automatic logic is_legal(input logic [63:0] pc);
    return (pc[1:0] == 2'b00) && (pc <= PC_MAX);
  endfunction

  assign ready = (state_q == S_FETCH) && (wait_q == WAIT_LAST);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wait_d     = wait_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    fault_d    = fault_q;
    count_d    = count_q;

    if (branch_taken_i) begin
      // Redirect flushes IF/ID even under stall; any word in flight is lost.
      pc_d       = branch_target_i;
      wait_d     = '0;
      if_valid_d = 1'b0;
      fault_d    = !is_legal(branch_target_i);
      state_d    = is_legal(branch_target_i) ? S_FETCH : S_FAULT;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (!is_legal(pc_q)) begin
            // Memory is never sampled at an illegal address.
            state_d = S_FAULT;
            fault_d = 1'b1;
            wait_d  = '0;
            if (!stall_i) if_valid_d = 1'b0;
          end else if (!ready) begin
            wait_d = wait_q + WAIT_W'(1);
            if (!stall_i) if_valid_d = 1'b0;
          end else if (!stall_i) begin
            if_instr_d = imem_instr_i;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            count_d    = count_q + 32'd1;
            pc_d       = pc_q + 64'd4;
            wait_d     = '0;
          end else begin
            // Word is ready but IF/ID is blocked: park with the address held
            // so the memory output stays valid until the stall clears.
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            if_instr_d = imem_instr_i;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            count_d    = count_q + 32'd1;
            pc_d       = pc_q + 64'd4;
            wait_d     = '0;
            state_d    = S_FETCH;
          end
        end
        S_FAULT: begin
          if (!stall_i) if_valid_d = 1'b0;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      wait_q     <= '0;
      if_pc_q    <= 64'd0;
      if_instr_q <= 32'd0;
      if_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wait_q     <= wait_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign if_id_pc_o    = if_pc_q;
  assign if_id_instr_o = if_instr_q;
  assign if_id_valid_o = if_valid_q;
  assign fetch_fault_o = fault_q;
  assign fetch_count_o = count_q;

endmodule
`default_nettype wire
